alu_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 8-bit ALU between two requesters: the execute stage (port 0) and the address/increment unit (port 1).
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand, op and shamt inputs from registered copies.
- Waits the ALU's fixed latency, then captures out/flags and returns them as a one-cycle response pulse to the requester that issued the operation.

---
 rtl/alu_arb_if.sv | 37 +++
 rtl/alu_arb.sv | 154 +++++++++++++++
 tb/tb_alu_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// One requester <-> arbiter channel: operation request with valid/ready and a
// one-cycle, non-backpressured response strobe carrying the ALU result and flags.
interface alu_arb_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] req_op;
    logic [2:0] req_shamt;
    logic       rsp_valid;
    logic [7:0] rsp_out;
    logic [3:0] rsp_flags;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output req_op,
        output req_shamt,
        input  req_ready,
        input  rsp_valid,
        input  rsp_out,
        input  rsp_flags
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  req_op,
        input  req_shamt,
        output req_ready,
        output rsp_valid,
        output rsp_out,
        output rsp_flags
    );
endinterface

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one fixed-latency 8-bit ALU between two requesters;
// each result returns as a one-cycle response pulse to the port that issued it.
module alu_arb #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_arb_if.slave   port0,
    alu_arb_if.slave   port1,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic [2:0] alu_shamt,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic       busy
);
    localparam logic [2:0] LatCnt = 3'(LAT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e     state_q, state_d;
    logic [1:0] valid;
    logic [1:0] grant;
    logic [1:0] ready;
    logic       accept;
    logic       sel;
    logic       done;
    logic [2:0] cnt_q, cnt_d;
    logic       owner_q;
    logic       last_q;
    logic [7:0] a_q, b_q;
    logic [2:0] op_q, shamt_q;
    logic [1:0] rsp_valid_q;
    logic [7:0] out0_q, out1_q;
    logic [3:0] flags0_q, flags1_q;

    assign valid = {port1.req_valid, port0.req_valid};

    // Ties go to the port that did not win the previous grant.
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StWait;
            StWait:  if (cnt_q == 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = (state_q == StIdle) ? grant : 2'b00;
        busy  = (state_q == StWait);
        done  = (state_q == StWait) && (cnt_q == 3'd1);
    end

    assign accept = |(valid & ready);
    assign sel    = ready[1];

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = LatCnt;
        end else if (busy) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                owner_q <= sel;
                last_q  <= sel;
            end
        end
    end

    // Operands are only loaded on accept, so they stay stable through WAIT and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            op_q    <= 3'd0;
            shamt_q <= 3'd0;
        end else if (accept) begin
            a_q     <= sel ? port1.req_a     : port0.req_a;
            b_q     <= sel ? port1.req_b     : port0.req_b;
            op_q    <= sel ? port1.req_op    : port0.req_op;
            shamt_q <= sel ? port1.req_shamt : port0.req_shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 2'b00;
            out0_q      <= 8'd0;
            out1_q      <= 8'd0;
            flags0_q    <= 4'd0;
            flags1_q    <= 4'd0;
        end else begin
            rsp_valid_q <= 2'b00;
            if (done) begin
                rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                if (owner_q) begin
                    out1_q   <= alu_out;
                    flags1_q <= alu_flags;
                end else begin
                    out0_q   <= alu_out;
                    flags0_q <= alu_flags;
                end
            end
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_shamt = shamt_q;

    assign port0.req_ready = ready[0];
    assign port1.req_ready = ready[1];
    assign port0.rsp_valid = rsp_valid_q[0];
    assign port1.rsp_valid = rsp_valid_q[1];
    assign port0.rsp_out   = out0_q;
    assign port1.rsp_out   = out1_q;
    assign port0.rsp_flags = flags0_q;
    assign port1.rsp_flags = flags1_q;

    // The 3-bit down-counter cannot represent a zero or >7 latency.
    lat_legal_a: assert property (@(posedge clk) (LAT >= 1) && (LAT <= 7))
        else $error("alu_arb: LAT=%0d outside 1..7", LAT);
endmodule

// File: tb/tb_alu_arb.sv
// Randomised bench for alu_arb: two instances (LAT=1 and LAT=3) driven by queued requesters
// and checked every cycle against a transaction-level model of grants, latency and holds.
module tb_alu_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arb_if i10 ();
    alu_arb_if i11 ();
    alu_arb_if i30 ();
    alu_arb_if i31 ();

    logic [7:0] a1_a, a1_b, a3_a, a3_b, a1_o, a3_o;
    logic [2:0] a1_op, a1_sh, a3_op, a3_sh;
    logic [3:0] a1_f, a3_f;
    logic       bsy [2];

    alu_arb #(.LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .port0(i10), .port1(i11),
        .alu_a(a1_a), .alu_b(a1_b), .alu_op(a1_op), .alu_shamt(a1_sh),
        .alu_out(a1_o), .alu_flags(a1_f), .busy(bsy[0])
    );

    alu_arb #(.LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .port0(i30), .port1(i31),
        .alu_a(a3_a), .alu_b(a3_b), .alu_op(a3_op), .alu_shamt(a3_sh),
        .alu_out(a3_o), .alu_flags(a3_f), .busy(bsy[1])
    );

    // Bench ALU: flags = {overflow, negative, zero, carry}.
    function automatic logic [11:0] alu_ref(input logic [21:0] x);
        logic [7:0] a, b, r;
        logic [2:0] op, sh;
        logic [8:0] s;
        logic       c, o;
        {a, b, op, sh} = x;
        c = 1'b0;
        o = 1'b0;
        s = 9'd0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0];
                c = s[8];
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << sh;
            3'd6:    r = a >> sh;
            default: r = a;
        endcase
        return {o, r[7], (r == 8'd0), c, r};
    endfunction

    always_comb {a1_f, a1_o} = alu_ref({a1_a, a1_b, a1_op, a1_sh});
    always_comb {a3_f, a3_o} = alu_ref({a3_a, a3_b, a3_op, a3_sh});

    // Requester index i = 2*dut + port.
    logic        v   [4];
    logic [21:0] dat [4];
    logic        hs  [4] = '{default: 1'b0};
    logic [21:0] fifo [4][64];
    int          wr [4] = '{default: 0};
    int          rd [4];
    int          dens = 100;

    logic        rdy [4];
    logic        rv  [4];
    logic [7:0]  ro  [4];
    logic [3:0]  rf  [4];
    logic [21:0] aluv [2];

    assign i10.req_valid = v[0];
    assign i11.req_valid = v[1];
    assign i30.req_valid = v[2];
    assign i31.req_valid = v[3];
    assign {i10.req_a, i10.req_b, i10.req_op, i10.req_shamt} = dat[0];
    assign {i11.req_a, i11.req_b, i11.req_op, i11.req_shamt} = dat[1];
    assign {i30.req_a, i30.req_b, i30.req_op, i30.req_shamt} = dat[2];
    assign {i31.req_a, i31.req_b, i31.req_op, i31.req_shamt} = dat[3];

    assign rdy[0] = i10.req_ready;
    assign rdy[1] = i11.req_ready;
    assign rdy[2] = i30.req_ready;
    assign rdy[3] = i31.req_ready;
    assign rv[0]  = i10.rsp_valid;
    assign rv[1]  = i11.rsp_valid;
    assign rv[2]  = i30.rsp_valid;
    assign rv[3]  = i31.rsp_valid;
    assign ro[0]  = i10.rsp_out;
    assign ro[1]  = i11.rsp_out;
    assign ro[2]  = i30.rsp_out;
    assign ro[3]  = i31.rsp_out;
    assign rf[0]  = i10.rsp_flags;
    assign rf[1]  = i11.rsp_flags;
    assign rf[2]  = i30.rsp_flags;
    assign rf[3]  = i31.rsp_flags;
    assign aluv[0] = {a1_a, a1_b, a1_op, a1_sh};
    assign aluv[1] = {a3_a, a3_b, a3_op, a3_sh};

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requesters hold valid until the handshake, then take the next queued op.
    initial begin
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0;
            dat[i] = '0;
            rd[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    v[i] = 1'b0;
                    rd[i]++;
                end
                if (!v[i] && rd[i] != wr[i] && $urandom_range(0, 99) < dens) begin
                    v[i] = 1'b1;
                    dat[i] = fifo[i][rd[i] % 64];
                end
            end
        end
    end

    // Transaction-level reference state per instance.
    logic        m_act  [2];
    int          m_done [2];
    logic        m_own  [2];
    logic        m_last [2];
    logic [11:0] m_res  [2];
    logic [21:0] m_alu  [2];
    logic [11:0] m_hold [2][2];
    int          rcnt   [2][2] = '{default: 0};
    int          base   [2][2];

    task automatic model_step(input int d);
        int         lat = (d == 0) ? 1 : 3;
        int         b = d * 2;
        logic [1:0] ev;
        logic [1:0] er;
        if (!rst_n) begin
            m_act[d] = 1'b0;
            m_last[d] = 1'b1;
            m_alu[d] = '0;
            m_hold[d][0] = '0;
            m_hold[d][1] = '0;
            check_eq($sformatf("d%0d_rst_busy", d), bsy[d], 0);
            check_eq($sformatf("d%0d_rst_alu", d), aluv[d], 0);
            for (int p = 0; p < 2; p++) begin
                check_eq($sformatf("d%0d_rst_rsp%0d", d, p), {rv[b+p], rf[b+p], ro[b+p]}, 0);
            end
            return;
        end
        ev = 2'b00;
        if (m_act[d] && cyc == m_done[d]) begin
            ev[m_own[d]] = 1'b1;
            m_hold[d][m_own[d]] = m_res[d];
            m_act[d] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("d%0d_rsp%0d_valid", d, p), rv[b+p], ev[p]);
            check_eq($sformatf("d%0d_rsp%0d_data", d, p), {rf[b+p], ro[b+p]}, m_hold[d][p]);
            if (rv[b+p]) rcnt[d][p]++;
        end
        check_eq($sformatf("d%0d_busy", d), bsy[d], m_act[d]);
        check_eq($sformatf("d%0d_alu_in", d), aluv[d], m_alu[d]);
        er = 2'b00;
        if (!m_act[d]) begin
            if (v[b] && v[b+1]) er[m_last[d] ? 0 : 1] = 1'b1;
            else er = {v[b+1], v[b]};
        end
        for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("d%0d_ready%0d", d, p), rdy[b+p], er[p]);
        end
        for (int p = 0; p < 2; p++) begin
            if (v[b+p] && er[p]) begin
                m_act[d] = 1'b1;
                m_done[d] = cyc + 1 + lat;
                m_own[d] = p[0];
                m_last[d] = p[0];
                m_alu[d] = dat[b+p];
                m_res[d] = alu_ref(dat[b+p]);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) hs[i] = v[i] && rdy[i] && rst_n;
        model_step(0);
        model_step(1);
    end

    task automatic push(input int i, input logic [21:0] x);
        fifo[i][wr[i] % 64] = x;
        wr[i]++;
    endtask

    task automatic snap();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) base[d][p] = rcnt[d][p];
    endtask

    function automatic logic all_idle();
        logic q = !bsy[0] && !bsy[1] && !m_act[0] && !m_act[1];
        for (int i = 0; i < 4; i++) q = q && !v[i] && (rd[i] == wr[i]);
        return q;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (n < budget && !all_idle()) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_drained"}, all_idle(), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op on LAT=1.
        snap();
        push(0, {8'h12, 8'h34, 3'd0, 3'd0});
        drain("single", 50);
        check_eq("single_rsp0_cnt", rcnt[0][0] - base[0][0], 1);
        check_eq("single_rsp1_cnt", rcnt[0][1] - base[0][1], 0);
        check_eq("single_out", ro[0], 8'h46);
        check_eq("single_flags", rf[0], 4'h0);

        // Tie straight after reset: port 0 first.
        do_reset();
        snap();
        push(0, {8'h01, 8'h02, 3'd0, 3'd0});
        push(1, {8'h10, 8'h20, 3'd3, 3'd0});
        drain("tie", 50);
        check_eq("tie_rsp0_cnt", rcnt[0][0] - base[0][0], 1);
        check_eq("tie_rsp1_cnt", rcnt[0][1] - base[0][1], 1);
        check_eq("tie_out0", ro[0], 8'h03);
        check_eq("tie_out1", ro[1], 8'h30);

        // Fairness: both ports continuously valid for 8 ops.
        snap();
        for (int k = 0; k < 4; k++) begin
            push(0, 22'($urandom));
            push(1, 22'($urandom));
        end
        drain("fair", 100);
        check_eq("fair_rsp0_cnt", rcnt[0][0] - base[0][0], 4);
        check_eq("fair_rsp1_cnt", rcnt[0][1] - base[0][1], 4);

        // LAT=3 with a competing request arriving during WAIT.
        snap();
        push(3, {8'hFF, 8'h01, 3'd0, 3'd0});
        repeat (2) @(posedge clk);
        push(2, {8'h0F, 8'hF0, 3'd4, 3'd0});
        drain("lat3", 100);
        check_eq("lat3_rsp1_cnt", rcnt[1][1] - base[1][1], 1);
        check_eq("lat3_out1", ro[3], 8'h00);
        check_eq("lat3_flags1", rf[3], 4'h3);
        check_eq("lat3_out0", ro[2], 8'hFF);

        // Reset one cycle after accept aborts the operation.
        snap();
        push(2, {8'h33, 8'h44, 3'd0, 3'd0});
        n = 0;
        while (!bsy[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_accepted", bsy[1], 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", bsy[1], 0);
        check_eq("abort_alu", aluv[1], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check_eq("abort_no_rsp", rcnt[1][0] - base[1][0], 0);
        push(2, {8'h05, 8'h06, 3'd0, 3'd0});
        push(3, {8'h07, 8'h08, 3'd0, 3'd0});
        drain("abort_tie", 60);
        check_eq("abort_tie_cnt0", rcnt[1][0] - base[1][0], 1);
        check_eq("abort_tie_cnt1", rcnt[1][1] - base[1][1], 1);

        // Port 0's result holds across port 1's response.
        push(0, {8'h5A, 8'h00, 3'd0, 3'd0});
        drain("hold_a", 50);
        push(1, {8'hA5, 8'h00, 3'd0, 3'd0});
        drain("hold_b", 50);
        check_eq("hold_out0", ro[0], 8'h5A);
        check_eq("hold_out1", ro[1], 8'hA5);
        check_eq("hold_flags1", rf[1], 4'h4);

        // Random traffic on all four requesters.
        dens = 60;
        for (int k = 0; k < 48; k++) begin
            push($urandom_range(0, 3), 22'($urandom));
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        drain("random", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL global_timeout: got=cycle %0d expected=finish earlier", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
